// File: rtl/ahb2_mem_arbiter.sv
// Round-robin arbiter for two native requesters sharing one AHB2 memory slave.
// Pipelines address and data phases and routes read data / errors to the owner.
module ahb2_mem_arbiter #(
  parameter int ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [31:0]           wdata0_i,
  input  logic [31:0]           wdata1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [31:0]           rdata0_o,
  output logic [31:0]           rdata1_o,
  output logic                  err0_o,
  output logic                  err1_o,
  output logic                  hsel_o,
  output logic [1:0]            htrans_o,
  output logic [ADDR_WIDTH+1:0] haddr_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [31:0]           hwdata_o,
  output logic                  hreadyi_o,
  input  logic [31:0]           hrdata_i,
  input  logic                  hreadyo_i,
  input  logic                  hresp_i
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic        rrLast_q, rrLast_d;
  logic        pendValid_q, pendValid_d;
  logic        pendOwner_q, pendOwner_d;
  logic        dpValid_q, dpValid_d;
  logic        dpOwner_q, dpOwner_d;
  logic        dpWrite_q, dpWrite_d;
  logic [31:0] hwdata_q, hwdata_d;

  logic                  ownerValid;
  logic                  owner;
  logic                  ownerWe;
  logic [ADDR_WIDTH-1:0] ownerAddr;
  logic [31:0]           ownerWdata;
  logic                  accept;
  logic                  complete;
  logic                  readOk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rrLast_q    <= 1'b1;
      pendValid_q <= 1'b0;
      pendOwner_q <= 1'b0;
      dpValid_q   <= 1'b0;
      dpOwner_q   <= 1'b0;
      dpWrite_q   <= 1'b0;
      hwdata_q    <= '0;
    end else begin
      rrLast_q    <= rrLast_d;
      pendValid_q <= pendValid_d;
      pendOwner_q <= pendOwner_d;
      dpValid_q   <= dpValid_d;
      dpOwner_q   <= dpOwner_d;
      dpWrite_q   <= dpWrite_d;
      hwdata_q    <= hwdata_d;
    end
  end

  // A stalled address phase keeps its owner so the bus stays stable across wait states.
  always_comb begin
    ownerValid = 1'b0;
    owner      = 1'b0;
    if (rst_n) begin
      if (pendValid_q) begin
        ownerValid = 1'b1;
        owner      = pendOwner_q;
      end else if (req0_i && req1_i) begin
        ownerValid = 1'b1;
        owner      = ~rrLast_q;
      end else if (req0_i) begin
        ownerValid = 1'b1;
        owner      = 1'b0;
      end else if (req1_i) begin
        ownerValid = 1'b1;
        owner      = 1'b1;
      end
    end
    ownerWe    = owner ? we1_i    : we0_i;
    ownerAddr  = owner ? addr1_i  : addr0_i;
    ownerWdata = owner ? wdata1_i : wdata0_i;
  end

  assign accept   = ownerValid & hreadyo_i;
  assign complete = rst_n & dpValid_q & hreadyo_i;

  always_comb begin
    rrLast_d    = rrLast_q;
    pendValid_d = pendValid_q;
    pendOwner_d = pendOwner_q;
    dpValid_d   = dpValid_q;
    dpOwner_d   = dpOwner_q;
    dpWrite_d   = dpWrite_q;
    hwdata_d    = hwdata_q;
    if (accept) begin
      rrLast_d    = owner;
      pendValid_d = 1'b0;
      dpValid_d   = 1'b1;
      dpOwner_d   = owner;
      dpWrite_d   = ownerWe;
      if (ownerWe) begin
        hwdata_d = ownerWdata;
      end
    end else if (ownerValid && !hreadyo_i) begin
      pendValid_d = 1'b1;
      pendOwner_d = owner;
    end else if (!ownerValid && hreadyo_i) begin
      dpValid_d = 1'b0;
    end
  end

  // An errored read reports err only; rvalid is reserved for good read data.
  always_comb begin
    readOk    = complete & ~dpWrite_q & ~hresp_i;
    gnt0_o    = accept & ~owner;
    gnt1_o    = accept & owner;
    rvalid0_o = readOk & ~dpOwner_q;
    rvalid1_o = readOk & dpOwner_q;
    rdata0_o  = rvalid0_o ? hrdata_i : 32'h0;
    rdata1_o  = rvalid1_o ? hrdata_i : 32'h0;
    err0_o    = complete & hresp_i & ~dpOwner_q;
    err1_o    = complete & hresp_i & dpOwner_q;
    hsel_o    = 1'b1;
    htrans_o  = ownerValid ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_o   = ownerValid ? {2'b00, ownerAddr} : '0;
    hwrite_o  = ownerValid & ownerWe;
    hsize_o   = 3'b010;
    hwdata_o  = hwdata_q;
    hreadyi_o = hreadyo_i;
  end

endmodule
